// File: rtl/uart_arb_pkg.sv
// Shared definitions for the debug-UART transmit arbiter: FSM encodings and defaults.
package uart_arb_pkg;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_HOLD_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping past N_REQ-1.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             found,
    output logic [IDW-1:0]   idx
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [2*N_REQ-1:0] w_shift;
    logic [N_REQ-1:0]   w_rot;
    logic [IDW-1:0]     w_enc;
    logic [IDW:0]       w_sum;

    // Rotate so that bit 0 corresponds to the requester at ptr.
    assign w_dbl   = {req, req};
    assign w_shift = w_dbl >> ptr;
    assign w_rot   = w_shift[N_REQ-1:0];

    // Priority-encode the lowest set bit of the rotated vector.
    always_comb begin
        found = 1'b0;
        w_enc = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            found = found | w_rot[k];
            w_enc = w_rot[k] ? IDW'(k) : w_enc;
        end
    end

    // Un-rotate: add ptr back and wrap modulo N_REQ (N_REQ need not be a power of two).
    assign w_sum = {1'b0, w_enc} + {1'b0, ptr};
    assign idx   = (w_sum >= (IDW+1)'(N_REQ)) ? IDW'(w_sum - (IDW+1)'(N_REQ))
                                               : w_sum[IDW-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte streams, granting whole messages round-robin.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ack,
    output logic                       grant_active,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       uart_valid,
    output logic [7:0]                 uart_data,
    input  logic                       uart_ack,
    input  logic                       uart_ready
);

    localparam int IDW = $clog2(N_REQ);
    localparam int HCW = $clog2(HOLD_TIMEOUT);

    arb_state_e     r_state;
    arb_state_e     w_state_next;
    logic           r_uart_valid;
    logic           w_uart_valid_next;
    logic [7:0]     r_uart_data;
    logic [7:0]     w_uart_data_next;
    logic           r_grant_active;
    logic           w_grant_active_next;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] w_grant_id_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] w_rr_ptr_next;
    logic [HCW-1:0] r_hold_cnt;
    logic [HCW-1:0] w_hold_cnt_next;
    logic           r_last_q;
    logic           w_last_q_next;

    logic           w_found;
    logic [IDW-1:0] w_pick_idx;
    logic [7:0]     w_pick_byte;
    logic [7:0]     w_hold_byte;
    logic [IDW-1:0] w_ptr_after;
    logic [HCW-1:0] w_hold_max;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    assign w_pick_byte = req_data[{w_pick_idx, 3'b000} +: 8];
    assign w_hold_byte = req_data[{r_grant_id, 3'b000} +: 8];
    assign w_ptr_after = (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + IDW'(1);
    assign w_hold_max  = HCW'(HOLD_TIMEOUT - 1);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath-register next values.
    always_comb begin
        w_state_next        = r_state;
        w_uart_valid_next   = r_uart_valid;
        w_uart_data_next    = r_uart_data;
        w_grant_active_next = r_grant_active;
        w_grant_id_next     = r_grant_id;
        w_rr_ptr_next       = r_rr_ptr;
        w_hold_cnt_next     = r_hold_cnt;
        w_last_q_next       = r_last_q;
        case (r_state)
            ST_IDLE: begin
                if (uart_ready && w_found) begin
                    w_uart_data_next    = w_pick_byte;
                    w_uart_valid_next   = 1'b1;
                    w_grant_id_next     = w_pick_idx;
                    w_grant_active_next = 1'b1;
                    w_last_q_next       = req_last[w_pick_idx];
                    w_state_next        = ST_SEND;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (uart_ack) begin
                    w_uart_valid_next = 1'b0;
                    if (r_last_q) begin
                        w_rr_ptr_next       = w_ptr_after;
                        w_grant_active_next = 1'b0;
                        w_state_next        = ST_IDLE;
                    end else begin
                        w_hold_cnt_next = '0;
                        w_state_next    = ST_HOLD;
                    end
                end else begin
                    w_state_next = ST_SEND;
                end
            end
            ST_HOLD: begin
                if (uart_ready && req_valid[r_grant_id]) begin
                    w_uart_data_next  = w_hold_byte;
                    w_last_q_next     = req_last[r_grant_id];
                    w_uart_valid_next = 1'b1;
                    w_state_next      = ST_SEND;
                end else if (r_hold_cnt == w_hold_max) begin
                    // Grantee stalled too long mid-message: release as if it had ended.
                    w_rr_ptr_next       = w_ptr_after;
                    w_grant_active_next = 1'b0;
                    w_state_next        = ST_IDLE;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + HCW'(1);
                end
            end
            default: begin
                w_uart_valid_next   = 1'b0;
                w_grant_active_next = 1'b0;
                w_state_next        = ST_IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_uart_valid   <= 1'b0;
            r_uart_data    <= 8'h00;
            r_grant_active <= 1'b0;
            r_grant_id     <= '0;
            r_rr_ptr       <= '0;
            r_hold_cnt     <= '0;
            r_last_q       <= 1'b0;
        end else begin
            r_uart_valid   <= w_uart_valid_next;
            r_uart_data    <= w_uart_data_next;
            r_grant_active <= w_grant_active_next;
            r_grant_id     <= w_grant_id_next;
            r_rr_ptr       <= w_rr_ptr_next;
            r_hold_cnt     <= w_hold_cnt_next;
            r_last_q       <= w_last_q_next;
        end
    end

    // Consume pulse to the grantee; reset masks an ack arriving in the same cycle.
    always_comb begin
        req_ack = '0;
        if (rst_n && uart_ack && (r_state == ST_SEND)) begin
            req_ack[r_grant_id] = 1'b1;
        end else begin
            req_ack = '0;
        end
    end

    assign uart_valid   = r_uart_valid;
    assign uart_data    = r_uart_data;
    assign grant_active = r_grant_active;
    assign grant_id     = r_grant_id;

endmodule
